// File: rtl/oam_dma_arbiter_if.sv
// Shared 6502 bus bundle: CPU side, memory/PPU side and the arbiter status lines.
// slave = arbiter view, master = CPU/memory environment view.
interface oam_dma_arbiter_if;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_d_out;
  logic        cpu_write;
  logic        cpu_ready;
  logic [15:0] bus_addr;
  logic [7:0]  bus_d_out;
  logic        bus_write;
  logic [7:0]  bus_d_in;
  logic        dma_active;

  modport slave (
    input  cpu_addr, cpu_d_out, cpu_write, bus_d_in,
    output cpu_ready, bus_addr, bus_d_out, bus_write, dma_active
  );

  modport master (
    output cpu_addr, cpu_d_out, cpu_write, bus_d_in,
    input  cpu_ready, bus_addr, bus_d_out, bus_write, dma_active
  );
endinterface

// File: rtl/oam_dma_arbiter.sv
// Arbitrates the shared 6502 bus between the CPU and the sprite OAM DMA engine.
// A CPU write to TRIGGER_ADDR stalls the core and copies one page into OAM.
module oam_dma_arbiter #(
  parameter logic [15:0] TRIGGER_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004,
  parameter int unsigned XFER_LEN      = 256
) (
  input logic              clk,
  input logic              reset,
  oam_dma_arbiter_if.slave io
);
  // state | meaning
  // IDLE  | cpu owns the bus, signals pass straight through
  // HALT  | first stalled cycle, dummy read of the source page
  // ALIGN | extra dummy read so that every READ lands on an even cycle
  // READ  | fetch source byte {page,idx} into buf
  // WRITE | store buf to OAM_DATA_ADDR, advance or finish
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HALT  = 3'd1,
    ALIGN = 3'd2,
    READ  = 3'd3,
    WRITE = 3'd4
  } state_t;

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  state_t     state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] buf_q, buf_d;
  logic       parity_q, parity_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      page_q   <= 8'h00;
      idx_q    <= 8'h00;
      buf_q    <= 8'h00;
      parity_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      page_q   <= page_d;
      idx_q    <= idx_d;
      buf_q    <= buf_d;
      parity_q <= parity_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    page_d       = page_q;
    idx_d        = idx_q;
    buf_d        = buf_q;
    parity_d     = ~parity_q;
    io.bus_addr  = io.cpu_addr;
    io.bus_d_out = io.cpu_d_out;
    io.bus_write = io.cpu_write;

    case (state_q)
      IDLE: begin
        // the trigger write itself still reaches the bus this cycle
        if (io.cpu_write && io.cpu_addr == TRIGGER_ADDR) begin
          page_d  = io.cpu_d_out;
          idx_d   = 8'h00;
          state_d = HALT;
        end
      end
      HALT: begin
        io.bus_addr  = {page_q, 8'h00};
        io.bus_d_out = 8'h00;
        io.bus_write = 1'b0;
        state_d      = parity_q ? READ : ALIGN;
      end
      ALIGN: begin
        io.bus_addr  = {page_q, 8'h00};
        io.bus_d_out = 8'h00;
        io.bus_write = 1'b0;
        state_d      = READ;
      end
      READ: begin
        io.bus_addr  = {page_q, idx_q};
        io.bus_d_out = 8'h00;
        io.bus_write = 1'b0;
        buf_d        = io.bus_d_in;
        state_d      = WRITE;
      end
      WRITE: begin
        io.bus_addr  = OAM_DATA_ADDR;
        io.bus_d_out = buf_q;
        io.bus_write = 1'b1;
        if (idx_q == LAST_IDX) begin
          idx_d   = 8'h00;
          state_d = IDLE;
        end else begin
          idx_d   = idx_q + 8'h01;
          state_d = READ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign io.cpu_ready  = (state_q == IDLE);
  assign io.dma_active = (state_q != IDLE);

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Directed bench for oam_dma_arbiter: OAM write data is scoreboarded against a
// memory model; stall length, read addresses and READ parity are checked per transfer.
module tb_oam_dma_arbiter;
  localparam logic [15:0] TRIG = 16'h4014;
  localparam logic [15:0] OAM  = 16'h2004;
  localparam int          XLEN = 256;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   pass_cnt = 0;
  int   fail_cnt = 0;
  int   total_cnt = 0;
  logic [7:0] mem [0:65535];
  logic [7:0] sb_q [$];

  oam_dma_arbiter_if io ();

  oam_dma_arbiter #(
    .TRIGGER_ADDR (TRIG),
    .OAM_DATA_ADDR(OAM),
    .XFER_LEN     (XLEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .io   (io.slave)
  );

  always #5 clk = ~clk;

  // cycle index since reset released; parity of a cycle is cyc[0]
  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  assign io.bus_d_in = mem[io.bus_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard: every OAM write must match the next expected byte
  always @(negedge clk) begin
    if (io.bus_write === 1'b1 && io.bus_addr === OAM) begin
      check("oam_wr_expected", 32'(sb_q.size() != 0), 32'd1);
      if (sb_q.size() != 0) check("oam_wr_data", 32'(io.bus_d_out), 32'(sb_q.pop_front()));
    end
  end

  task automatic drive_cpu(input logic [15:0] a, input logic [7:0] d, input logic w);
    io.cpu_addr  = a;
    io.cpu_d_out = d;
    io.cpu_write = w;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
    drive_cpu(16'h0000, 8'h00, 1'b0);
  endtask

  // called at +1 of the intended trigger cycle
  task automatic trigger(input logic [7:0] page, output int t_cyc);
    t_cyc = cyc;
    drive_cpu(TRIG, page, 1'b1);
    for (int i = 0; i < XLEN; i++) sb_q.push_back(mem[{page, 8'(i)}]);
    #1;
    check("trig_passthrough_we", 32'(io.bus_write), 32'd1);
    check("trig_passthrough_addr", 32'(io.bus_addr), 32'(TRIG));
  endtask

  // runs until cpu_ready returns; leaves time at +1 of the first IDLE cycle
  task automatic run_transfer(input int t_cyc, input logic [7:0] page);
    int stalls = 0, writes = 0, bad_par = 0, stray = 0, act_bad = 0;
    logic [15:0] prev_addr = 16'h0, first_rd = 16'h0, last_rd = 16'h0;
    bit done = 0;
    int exp_stall;
    exp_stall = (((t_cyc + 1) % 2) == 1) ? 1 + 2 * XLEN : 2 + 2 * XLEN;
    for (int k = 0; k < 700 && !done; k++) begin
      @(posedge clk);
      #1;
      if (io.cpu_ready === 1'b1) begin
        drive_cpu(16'h0000, 8'h00, 1'b0);
        if (io.dma_active !== 1'b0) act_bad++;
        done = 1;
      end else begin
        stalls++;
        drive_cpu(TRIG, 8'h77, 1'b1);
        #1;
        if (io.dma_active !== 1'b1) act_bad++;
        if (io.bus_write === 1'b1) begin
          if (io.bus_addr === OAM) begin
            if (writes == 0) first_rd = prev_addr;
            last_rd = prev_addr;
            writes++;
            if (cyc[0] == 1'b0) bad_par++;
          end else stray++;
        end
        prev_addr = io.bus_addr;
      end
    end
    check("xfer_done", 32'(done), 32'd1);
    check("stall_cycles", 32'(stalls), 32'(exp_stall));
    check("oam_writes", 32'(writes), 32'(XLEN));
    check("first_read_addr", 32'(first_rd), 32'({page, 8'h00}));
    check("last_read_addr", 32'(last_rd), 32'({page, 8'hFF}));
    check("read_parity_odd", 32'(bad_par), 32'd0);
    check("stray_writes", 32'(stray), 32'd0);
    check("dma_active_bad", 32'(act_bad), 32'd0);
    check("sb_drained", 32'(sb_q.size()), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_cyc;
    int wcount;
    for (int a = 0; a < 65536; a++) mem[a] = 8'(a * 7 + (a >> 8));
    for (int i = 0; i < 256; i++) mem[16'h0300 + i] = 8'(i) ^ 8'hA5;
    drive_cpu(16'h0000, 8'h00, 1'b0);

    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst_cpu_ready", 32'(io.cpu_ready), 32'd1);
    check("rst_dma_active", 32'(io.dma_active), 32'd0);

    // passthrough read and write
    next_cycle();
    drive_cpu(16'h8000, 8'h11, 1'b0);
    #1;
    check("pt_rd_addr", 32'(io.bus_addr), 32'h8000);
    check("pt_rd_we", 32'(io.bus_write), 32'd0);
    check("pt_rd_ready", 32'(io.cpu_ready), 32'd1);
    next_cycle();
    drive_cpu(16'h0010, 8'h55, 1'b1);
    #1;
    check("pt_wr_addr", 32'(io.bus_addr), 32'h0010);
    check("pt_wr_data", 32'(io.bus_d_out), 32'h55);
    check("pt_wr_we", 32'(io.bus_write), 32'd1);
    check("pt_wr_active", 32'(io.dma_active), 32'd0);

    // trigger with odd HALT parity: trigger on an even cycle
    next_cycle();
    if (cyc[0] != 1'b0) next_cycle();
    trigger(8'h02, t_cyc);
    run_transfer(t_cyc, 8'h02);

    // even HALT parity: trigger on an odd cycle, forces ALIGN
    if (cyc[0] != 1'b1) next_cycle();
    trigger(8'h01, t_cyc);
    run_transfer(t_cyc, 8'h01);

    // pattern page then back-to-back retrigger in the first IDLE cycle
    next_cycle();
    trigger(8'h03, t_cyc);
    run_transfer(t_cyc, 8'h03);
    trigger(8'h03, t_cyc);
    run_transfer(t_cyc, 8'h03);

    // reset during the 100th OAM write
    next_cycle();
    trigger(8'h03, t_cyc);
    wcount = 0;
    for (int k = 0; k < 400 && wcount < 100; k++) begin
      @(posedge clk);
      #1;
      drive_cpu(16'h0000, 8'h00, 1'b0);
      #1;
      if (io.bus_write === 1'b1 && io.bus_addr === OAM) wcount++;
    end
    check("reached_100th_write", 32'(wcount), 32'd100);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive_cpu(16'h1234, 8'h9C, 1'b0);
    #1;
    check("rst_mid_ready", 32'(io.cpu_ready), 32'd1);
    check("rst_mid_active", 32'(io.dma_active), 32'd0);
    check("rst_mid_pt_addr", 32'(io.bus_addr), 32'h1234);
    check("rst_mid_pt_we", 32'(io.bus_write), 32'd0);
    check("rst_mid_remaining", 32'(sb_q.size()), 32'(XLEN - 100));
    sb_q.delete();
    repeat (20) next_cycle();

    // non-triggering accesses
    drive_cpu(16'h4015, 8'h05, 1'b1);
    next_cycle();
    #1;
    check("no_trig_4015", 32'(io.cpu_ready), 32'd1);
    drive_cpu(TRIG, 8'h05, 1'b0);
    next_cycle();
    #1;
    check("no_trig_rd_4014", 32'(io.cpu_ready), 32'd1);
    repeat (4) next_cycle();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
Owns the shared CPU address/data bus between the 6502 core (cpu) and the sprite OAM DMA engine. In IDLE it passes cpu bus signals straight to memory. A CPU write to TRIGGER_ADDR stalls the core via ready, then copies XFER_LEN bytes from page {data,8'h00} to OAM_DATA_ADDR as alternating read/write cycles. When the copy finishes it returns the bus to the CPU.

Parameters:
TRIGGER_ADDR, 16'h4014, CPU write address that starts DMA; the written byte is the source page.
OAM_DATA_ADDR, 16'h2004, destination address for every DMA write.
XFER_LEN, 256, bytes per transfer; legal range 1..256.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
cpu_addr  in  16  address from cpu
cpu_d_out  in  8  write data from cpu
cpu_write  in  1  write strobe from cpu
cpu_ready  out  1  drives cpu ready; 0 stalls the core
bus_addr  out  16  address to memory/PPU bus
bus_d_out  out  8  write data to bus
bus_write  out  1  write strobe to bus
bus_d_in  in  8  read data from bus (also wired directly to cpu d_in)
dma_active  out  1  high in every non-IDLE state

Behaviour:
- One clock (clk); reset is synchronous and active-high; all state updates on posedge clk.
- Registers and reset values: state=IDLE, page=0, idx=0, buf=0, parity=0. Outputs after reset: cpu_ready=1, dma_active=0, bus_* = cpu_* passthrough.
- parity toggles every cycle while not in reset. The first cycle after reset deasserts has parity 0 (even).
- cpu_ready = (state==IDLE), combinational. dma_active = !cpu_ready.
- IDLE: bus_addr=cpu_addr, bus_d_out=cpu_d_out, bus_write=cpu_write, all combinational.
- IDLE trigger: if cpu_write && cpu_addr==TRIGGER_ADDR, then:
  - the write still passes through to the bus in that cycle;
  - page<=cpu_d_out, idx<=0, state<=HALT.
  - Any other address, or a read of TRIGGER_ADDR, does not trigger.
- HALT (1 cycle): dummy read; bus_addr={page,8'h00}, bus_write=0, bus_d_out=0; data is discarded.
  - Next state: READ if parity==1 during HALT, otherwise ALIGN. This guarantees every READ falls on an even cycle.
- ALIGN (1 cycle): same bus drive as HALT. Next state: READ.
- READ: bus_addr={page,idx}, bus_write=0; buf<=bus_d_in at the end of the cycle. Next state: WRITE.
- WRITE: bus_addr=OAM_DATA_ADDR, bus_d_out=buf, bus_write=1.
  - If idx==XFER_LEN-1: state<=IDLE, idx<=0.
  - Otherwise: idx<=idx+1, state<=READ.
- idx is 8 bits. The source address never crosses the page boundary; the last byte read is {page,8'hFF} when XFER_LEN=256.
- Latency, counting the trigger cycle as T:
  - cpu_ready=0 from T+1 through the final WRITE.
  - Stall length is 1+2*XFER_LEN cycles if HALT parity is odd, 2+2*XFER_LEN cycles if even (513/514 for 256).
  - cpu_ready=1 in the cycle after the final WRITE.
- cpu inputs are ignored in every non-IDLE state; a trigger cannot re-arm mid-transfer.
- A trigger in the first IDLE cycle after completion is legal and starts a new transfer.
- Reset mid-operation: in the reset cycle's next edge, state=IDLE with all registers at their reset values. No further bus writes occur; the bus returns to passthrough immediately.
- bus_d_in is sampled only in READ.

Test Plan:
- Reset, then cpu read 16'h8000 and write 8'h55 to 16'h0010 -> bus mirrors cpu each cycle; cpu_ready=1; dma_active=0.
- Trigger with data 8'h02 while HALT parity is odd -> first READ addr 16'h0200; exactly 513 cycles with cpu_ready=0; last READ addr 16'h02FF.
- Same trigger while HALT parity is even -> one ALIGN cycle; 514 stall cycles; every READ on a parity-0 cycle.
- Memory model mem[16'h0300+i]=i^8'hA5, trigger page 8'h03 -> 256 writes to 16'h2004 carrying i^8'hA5 in order i=0..255, and no other bus writes.
- Assert reset during the 100th WRITE -> next cycle state IDLE, cpu_ready=1, bus passthrough, no further writes to 16'h2004.
- cpu write to 16'h4015 and cpu read of 16'h4014 -> no DMA. A trigger in the first cycle after a completed transfer -> a second full transfer.
